parallax_starfield: RTL

//  Multi-layer scrolling starfield pixel generator. Sits beside hvsync_generator:

---
 rtl/parallax_starfield_if.sv | 22 ++
 rtl/parallax_starfield.sv | 105 ++++++++++
 2 files changed

// File: rtl/parallax_starfield_if.sv
// Video timing bundle: hvsync_generator timing into the starfield, VGA pins and frame count out.
interface parallax_starfield_if;
    logic [15:0] hpos;
    logic [15:0] vpos;
    logic        display_on;
    logic        hsync_i;
    logic        vsync_i;
    logic        hsync;
    logic        vsync;
    logic [2:0]  rgb;
    logic [7:0]  frame_cnt;

    modport master (
        output hpos, vpos, display_on, hsync_i, vsync_i,
        input  hsync, vsync, rgb, frame_cnt
    );

    modport slave (
        input  hpos, vpos, display_on, hsync_i, vsync_i,
        output hsync, vsync, rgb, frame_cnt
    );
endinterface

// File: rtl/parallax_starfield.sv
// Multi-layer parallax starfield pixel generator fed by hvsync_generator timing.
// Optional far-star blinking is enabled by defining STARFIELD_TWINKLE_EN.
module parallax_starfield #(
    parameter int          NLAYERS = 3,
    parameter int          NBITS   = 16,
    parameter logic [31:0] TAPS    = 32'h0000_002D,
    parameter logic [31:0] SEED    = 32'h0000_ACE1,
    parameter int          DENSITY = 7
) (
    input logic                 clk,
    input logic                 reset,
    parallax_starfield_if.slave vid
);
    typedef logic [NBITS-1:0] lfsr_t;

    localparam lfsr_t TAP_MASK = TAPS[NBITS-1:0];
    localparam lfsr_t ONE      = lfsr_t'(1);

    function automatic lfsr_t step(input lfsr_t x);
        return {x[NBITS-2:0], 1'b0} ^ (x[NBITS-1] ? TAP_MASK : '0);
    endfunction

    // Layer k starts from SEED rotated left by 3*k so the layers are decorrelated.
    function automatic lfsr_t init_seed(input int k);
        lfsr_t s;
        lfsr_t r;
        int    sh;
        s  = SEED[NBITS-1:0];
        sh = (3 * k) % NBITS;
        r  = (sh == 0) ? s : lfsr_t'((s << sh) | (s >> (NBITS - sh)));
        return (r == '0) ? ONE : r;
    endfunction

    function automatic logic [7:0] adv_mask(input int k);
        return 8'((32'd1 << (NLAYERS - 1 - k)) - 32'd1);
    endfunction

    lfsr_t              seed_q [NLAYERS];
    lfsr_t              lfsr_q [NLAYERS];
    lfsr_t              cur    [NLAYERS];
    logic [NLAYERS-1:0] star;
    logic               frame_start;
    logic               any_star;
    logic [2:0]         colour_sel;
    logic [7:0]         frame_cnt_q;
    logic [2:0]         rgb_q;
    logic               hsync_q;
    logic               vsync_q;

    assign frame_start = (vid.hpos == 16'd0) && (vid.vpos == 16'd0);

    always_comb begin
        // NOTE: every combinationally assigned variable gets a default first, so no latch can be inferred.
        star       = '0;
        any_star   = 1'b0;
        colour_sel = 3'b000;
        for (int k = 0; k < NLAYERS; k++) begin
            cur[k]  = frame_start ? seed_q[k] : lfsr_q[k];
            star[k] = &cur[k][NBITS-1 -: DENSITY];
`ifdef STARFIELD_TWINKLE_EN
            if (k < NLAYERS - 1 && cur[k][6:3] == frame_cnt_q[5:2]) begin
                star[k] = 1'b0;
            end
`endif
            // Ascending scan, so the nearest (highest k) star present overrides the ones behind it.
            if (star[k]) begin
                any_star   = 1'b1;
                colour_sel = (k == NLAYERS - 1) ? 3'b111 : (cur[k][2:0] | 3'b001);
            end
        end
    end

    // NOTE: the seed/LFSR arrays are a few flops per layer, not a RAM, so they get reset values like any register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NLAYERS; k++) begin
                seed_q[k] <= init_seed(k);
                lfsr_q[k] <= init_seed(k);
            end
            frame_cnt_q <= 8'd0;
            rgb_q       <= 3'b000;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here updates from pre-edge values.
            for (int k = 0; k < NLAYERS; k++) begin
                lfsr_q[k] <= vid.display_on ? step(cur[k]) : cur[k];
                if (frame_start && ((frame_cnt_q & adv_mask(k)) == 8'd0)) begin
                    seed_q[k] <= step(seed_q[k]);
                end
            end
            if (frame_start) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            rgb_q   <= (vid.display_on && any_star) ? colour_sel : 3'b000;
            hsync_q <= vid.hsync_i;
            vsync_q <= vid.vsync_i;
        end
    end

    assign vid.rgb       = rgb_q;
    assign vid.hsync     = hsync_q;
    assign vid.vsync     = vsync_q;
    assign vid.frame_cnt = frame_cnt_q;
endmodule
